// File: rtl/pmp_checker_n_pkg.sv
// Shared PMP definitions: cfg layout, A-field encodings, access/privilege codes, CSR numbers.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package pmp_checker_n_pkg;

    // Address-matching mode held in pmpcfg.A
    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_a_e;

    // One pmpcfg byte, MSB first: L, reserved[1:0], A[1:0], X, W, R
    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    // Access type on the oper port
    localparam logic [1:0] READ    = 2'b00;
    localparam logic [1:0] WRITE   = 2'b01;
    localparam logic [1:0] EXECUTE = 2'b10;

    // Privilege level on the priv_mode port
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // CSR numbers (bits 11:0 of rw_addr)
    localparam logic [11:0] CSR_PMPCFG0       = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0      = 12'h3B0;
    localparam logic [11:0] CSR_PMPFAULT_ADDR = 12'h7C0;
    localparam logic [11:0] CSR_PMPFAULT_INFO = 12'h7C1;

    // Entry index reported when no entry matched
    localparam logic [3:0] ENTRY_NONE = 4'hF;

    // Legalise a written cfg byte: reserved bits read 0, W without R is dropped
    function automatic pmpcfg_t pmpcfg_warl(input logic [7:0] b);
        pmpcfg_t c;
        c      = pmpcfg_t'(b);
        c.rsvd = 2'b00;
        if (!c.r && c.w) begin
            c.w = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/pmp_checker_n_entry_match.sv
// One PMP entry's region decode and full/partial overlap test against an access span.
// Latency: purely combinational.
// Backpressure: none.
module pmp_entry_match
    import pmp_checker_n_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  pmp_a_e            a_mode,
    input  logic [ADDR_W-1:0] pmpaddr_cur,
    input  logic [ADDR_W-1:0] pmpaddr_prev,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        bytes,
    output logic              full_match,
    output logic              partial_match
);

    // Region bounds live in byte space, two bits wider than pmpaddr
    localparam int BW = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logic [ADDR_W:0]   span_end;
    logic [BW-1:0]     s_lo;
    logic [BW-1:0]     s_hi;
    logic [BW-1:0]     r_lo;
    logic [BW-1:0]     r_hi;
    logic [BW-1:0]     tor_top;
    logic [ADDR_W-1:0] napot_mask;
    logic              r_valid;
    logic              overlap;

    // Decode the region as inclusive [r_lo, r_hi] and test the span against it
    always_comb begin
        span_end   = {1'b0, addr} + (ADDR_W+1)'(bytes) - (ADDR_W+1)'(1);
        s_lo       = BW'(addr);
        s_hi       = BW'(span_end);
        tor_top    = {pmpaddr_cur, 2'b00};
        // Ones at the trailing-ones positions plus the first zero above them
        napot_mask = pmpaddr_cur ^ (pmpaddr_cur + ADDR_ONE);

        r_valid = 1'b0;
        r_lo    = '0;
        r_hi    = '0;
        case (a_mode)
            A_TOR: begin
                r_lo    = {pmpaddr_prev, 2'b00};
                r_hi    = tor_top - BW'(1);
                r_valid = (r_lo < tor_top);
            end
            A_NA4: begin
                r_lo    = {pmpaddr_cur, 2'b00};
                r_hi    = r_lo | BW'(3);
                r_valid = 1'b1;
            end
            A_NAPOT: begin
                // An all-ones pmpaddr gives mask all-ones: base 0, top of space
                r_lo    = {pmpaddr_cur & ~napot_mask, 2'b00};
                r_hi    = {pmpaddr_cur | napot_mask, 2'b11};
                r_valid = 1'b1;
            end
            default: begin
                r_valid = 1'b0;
            end
        endcase

        full_match    = r_valid && (s_lo >= r_lo) && (s_hi <= r_hi);
        overlap       = r_valid && (s_lo <= r_hi) && (s_hi >= r_lo);
        partial_match = overlap && !full_match;
    end

endmodule

// File: rtl/pmp_checker_n.sv
// N-entry RISC-V PMP: pmpcfg/pmpaddr CSRs plus a per-access grant/fault check.
// Latency: one cycle from chk_valid to rsp_valid; rdata is combinational from rw_addr.
// Backpressure: none, one check accepted every cycle. Optional PMP_FAULT_CAPTURE_EN adds sticky fault capture.
module pmp_checker_n
    import pmp_checker_n_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [31:0]       rw_addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic              chk_valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic [1:0]        oper,
    input  logic [1:0]        priv_mode,
    output logic              rsp_valid,
    output logic              rsp_grant,
    output logic              rsp_fault
`ifdef PMP_FAULT_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [7:0]        fault_info
`endif
);

    localparam int NUM_CFG = NUM_ENTRIES / 4;

    pmpcfg_t           cfg_q       [NUM_ENTRIES];
    logic [ADDR_W-1:0] addr_q      [NUM_ENTRIES];
    logic [ADDR_W-1:0] prev_addr   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] addr_locked;
    logic [NUM_ENTRIES-1:0] full_m;
    logic [NUM_ENTRIES-1:0] part_m;

    logic [11:0]       csr_a;
    logic [3:0]        bytes;
    logic [ADDR_W:0]   span_end;
    logic              span_wrap;
    logic              hit;
    logic              hit_full;
    logic [3:0]        hit_idx;
    pmpcfg_t           hit_cfg;
    logic              perm;
    logic              grant;
    logic              csr_unused;

    assign csr_a      = rw_addr[11:0];
    assign csr_unused = ^rw_addr[31:12];
    // size 3 maps to 8 bytes, which still fits the 4-bit byte count
    assign bytes      = 4'd1 << size;
    assign span_end   = {1'b0, addr} + (ADDR_W+1)'(bytes) - (ADDR_W+1)'(1);
    assign span_wrap  = span_end[ADDR_W];

    // Per-entry lock view and matcher; a locked TOR entry also freezes the pmpaddr below it
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        if (g == NUM_ENTRIES - 1) begin : g_top
            assign addr_locked[g] = cfg_q[g].l;
        end else begin : g_below
            assign addr_locked[g] = cfg_q[g].l | (cfg_q[g+1].l & (cfg_q[g+1].a == A_TOR));
        end

        if (g == 0) begin : g_first
            assign prev_addr[g] = '0;
        end else begin : g_rest
            assign prev_addr[g] = addr_q[g-1];
        end

        pmp_entry_match #(
            .ADDR_W (ADDR_W)
        ) u_match (
            .a_mode        (cfg_q[g].a),
            .pmpaddr_cur   (addr_q[g]),
            .pmpaddr_prev  (prev_addr[g]),
            .addr          (addr),
            .bytes         (bytes),
            .full_match    (full_m[g]),
            .partial_match (part_m[g])
        );
    end

    // CSR state: WARL cfg bytes, lock-respecting writes, L only cleared by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (csr_a == CSR_PMPCFG0 + 12'(i / 4) && !cfg_q[i].l) begin
                    cfg_q[i] <= pmpcfg_warl(wdata[8*(i%4) +: 8]);
                end
                if (csr_a == CSR_PMPADDR0 + 12'(i) && !addr_locked[i]) begin
                    addr_q[i] <= ADDR_W'(wdata);
                end
            end
        end
    end

    // Lowest-index matching entry decides, then apply mode-dependent permission rules
    always_comb begin
        hit      = 1'b0;
        hit_full = 1'b0;
        hit_idx  = ENTRY_NONE;
        hit_cfg  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!hit && (full_m[i] || part_m[i])) begin
                hit      = 1'b1;
                hit_full = full_m[i];
                hit_idx  = 4'(i);
                hit_cfg  = cfg_q[i];
            end
        end

        case (oper)
            READ:    perm = hit_cfg.r;
            WRITE:   perm = hit_cfg.w;
            EXECUTE: perm = hit_cfg.x;
            default: perm = 1'b0;
        endcase

        if (span_wrap) begin
            grant = 1'b0;
        end else if (hit) begin
            // Partial matches never pass; M mode only checks bits of locked entries
            if (priv_mode == PRIV_M) begin
                grant = hit_full && (!hit_cfg.l || perm);
            end else begin
                grant = hit_full && perm;
            end
        end else begin
            grant = (priv_mode == PRIV_M);
        end
    end

    // Registered response, one per accepted check
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_grant <= 1'b0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= chk_valid;
            rsp_grant <= chk_valid & grant;
            rsp_fault <= chk_valid & ~grant;
        end
    end

`ifdef PMP_FAULT_CAPTURE_EN
    logic [ADDR_W-1:0] fault_addr_q;
    logic [7:0]        fault_info_q;
    logic              fault_held_q;
    logic              fault_clr;
    logic              fault_cap;

    assign fault_clr  = wr_en && (csr_a == CSR_PMPFAULT_ADDR);
    // A clear in the same cycle reopens the slot for the fault arriving with it
    assign fault_cap  = chk_valid && !grant && (!fault_held_q || fault_clr);
    assign fault_addr = fault_addr_q;
    assign fault_info = fault_info_q;

    // Sticky capture of the first denied access since the last clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fault_addr_q <= '0;
            fault_info_q <= '0;
            fault_held_q <= 1'b0;
        end else if (fault_cap) begin
            fault_addr_q <= addr;
            fault_info_q <= {oper, priv_mode, hit_idx};
            fault_held_q <= 1'b1;
        end else if (fault_clr) begin
            fault_addr_q <= '0;
            fault_info_q <= '0;
            fault_held_q <= 1'b0;
        end
    end
`else
    logic fault_unused;
    assign fault_unused = ^hit_idx;
`endif

    // CSR read mux; unmapped addresses return 0
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (csr_a == CSR_PMPCFG0 + 12'(k)) begin
                rdata = {cfg_q[4*k+3], cfg_q[4*k+2], cfg_q[4*k+1], cfg_q[4*k]};
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (csr_a == CSR_PMPADDR0 + 12'(i)) begin
                rdata = 32'(addr_q[i]);
            end
        end
`ifdef PMP_FAULT_CAPTURE_EN
        if (csr_a == CSR_PMPFAULT_ADDR) begin
            rdata = 32'(fault_addr_q);
        end
        if (csr_a == CSR_PMPFAULT_INFO) begin
            rdata = {24'b0, fault_info_q};
        end
`endif
    end

endmodule
